font_rom_arbiter: RTL and testbench
===================================

// Module: font_rom_arbiter
// PURPOSE
//  Shares one synchronous font ROM (11-bit char address {code[6:0],line[3:0]}, 8-bit pixel row)
//  between N text generators: board labels, status banner, score/turn display.
//  Round-robin grant, one ROM access per clock, per-requester response strobe aligned to ROM output.
//  Sits between the letter/text generators and the single font ROM instance in the VGA pipeline.
// PARAMETERS
//  N_REQ    3   number of requesters (2..8)
//  ADDR_W   11  ROM address width
//  DATA_W   8   ROM data width (one glyph row)
//  ROM_LAT  1   ROM read latency in clocks, rom_addr edge to rom_data valid (1..4)
// PORTS
//  clk        in   1              system clock (pixel-domain clock)
//  rst        in   1              synchronous reset, active-low (0 = reset)
//  req_valid  in   N_REQ          per-requester read request
//  req_addr   in   N_REQ*ADDR_W   packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
//  req_ready  out  N_REQ          one-hot grant, combinational; accept = valid & ready at clk edge
//  rom_addr   out  ADDR_W         registered address to font ROM
//  rom_data   in   DATA_W         font ROM output
//  rsp_valid  out  N_REQ          one-hot: rom_data belongs to requester i this cycle
//  rsp_data   out  DATA_W         = rom_data (combinational passthrough)
// BEHAVIOUR
//  - Reset (rst==0 at edge): ptr=0, rom_addr=0, tag pipeline cleared, rsp_valid=0.
//    While rst==0, req_ready=0. In-flight reads are discarded, never reported.
//  - Arbitration, combinational: scan i = ptr, ptr+1, ..., wrapping mod N_REQ.
//    First i with req_valid[i]=1 gets req_ready[i]=1; all other bits 0.
//    No valid requests -> req_ready = 0.
//  - req_ready must not depend on req_addr. Requester may drop valid at any time.
//  - On accept of grant g at edge k:
//    * rom_addr <= req_addr[g]
//    * ptr <= (g+1)==N_REQ ? 0 : g+1
//    * tag pipeline stage 0 <= {1'b1, g}
//  - No accept at an edge: rom_addr holds; ptr holds; stage 0 <= invalid.
//  - Tag pipeline: ROM_LAT+... stages shift every clock, no stall.
//    ROM is never back-pressured, so each accepted request produces exactly one response.
//  - Response timing: rsp_valid[g]=1 for exactly one cycle, the cycle after edge k+ROM_LAT.
//    Total latency is ROM_LAT+1 edges from accept. rsp_valid bits are decoded from the last stage.
//  - Throughput: one accept per clock, sustained. Responses return in accept order.
//    Back-to-back responses to the same or different requesters are allowed.
//  - Fairness: a continuously requesting i waits at most N_REQ-1 accepts of others.
//  - Single requester active: granted every cycle.
//  - ptr wraps N_REQ-1 -> 0.
//  - Widths: ptr and tag index are $clog2(N_REQ) bits. Tag valid bit kept separately.
// TESTING  (N_REQ=3, ROM_LAT=1; ROM model: data = addr[7:0] ^ 8'hA5, 1-cycle latency)
//  1 Reset: hold rst=0 with all req_valid=1
//    -> req_ready=0, rsp_valid=0, rom_addr=0. After release, first grant goes to req 0.
//  2 Single: req1 valid addr 11'h412 for one cycle
//    -> rom_addr=11'h412 next cycle; rsp_valid=3'b010 and rsp_data=8'hB7 two edges after accept.
//  3 All three valid continuously, addrs 11'h010/11'h020/11'h030
//    -> grant order 0,1,2,0,1,2; rsp_valid sequence 001,010,100,... with data 8'hB5,8'h85,8'h95.
//  4 Wrap/fairness: ptr=2, only req0 and req1 valid
//    -> grant 0, then 1, then 0; no grant wasted on idle req2.
//  5 Reset mid-flight: accept req2, assert rst=0 on the next edge
//    -> no rsp_valid ever asserted for that read; ptr=0 after release.
//  6 Param sweep ROM_LAT=3: single accept at edge k
//    -> rsp_valid exactly one cycle, after edge k+3. 100 random request streams, scoreboard by tag.

Source files
------------

// File: rtl/font_rom_arbiter.sv
// -----------------------------------------------------------------------------
// font_rom_arbiter
//   Shares a single synchronous font ROM among N_REQ text generators (board
//   labels, status banner, score/turn display). Each clock at most one request
//   is granted, in round-robin order starting from r_ptr. The granted address
//   is registered onto rom_addr. A tag pipeline follows each read through the
//   ROM latency so the response strobe lines up with the ROM output.
//
// Ports
//   clk        in   pixel-domain system clock
//   rst        in   synchronous reset, active-low (0 = reset)
//   req_valid  in   [N_REQ]          per-requester read request
//   req_addr   in   [N_REQ*ADDR_W]   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready  out  [N_REQ]          one-hot combinational grant (0 while in reset)
//   rom_addr   out  [ADDR_W]         registered font ROM address
//   rom_data   in   [DATA_W]         font ROM read data
//   rsp_valid  out  [N_REQ]          one-hot: rom_data belongs to requester i this cycle
//   rsp_data   out  [DATA_W]         rom_data passthrough
// -----------------------------------------------------------------------------
module font_rom_arbiter #(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data
);

  localparam int PTR_W = $clog2(N_REQ);
  // One extra bit so ptr + offset never overflows before the modulo fold.
  localparam logic [PTR_W:0] N_REQ_W = (PTR_W+1)'(N_REQ);

  logic [PTR_W-1:0]             r_ptr;
  logic [ADDR_W-1:0]            r_rom_addr;
  // Stage 0 is loaded at the accept edge; stage ROM_LAT lines up with rom_data.
  logic [ROM_LAT:0]             r_tag_vld;
  logic [ROM_LAT:0][PTR_W-1:0]  r_tag_idx;

  logic [N_REQ-1:0]             w_grant;
  logic [PTR_W-1:0]             w_gidx;
  logic                         w_found;
  logic [PTR_W:0]               w_cand;
  logic                         w_accept;
  logic [PTR_W-1:0]             w_ptr_nxt;

  // Round-robin scan from r_ptr; depends only on req_valid and r_ptr.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_cand >= N_REQ_W) begin
        w_cand = w_cand - N_REQ_W;
      end
      if (!w_found && req_valid[w_cand[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_cand[PTR_W-1:0];
      end
    end
    if (w_found) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  assign req_ready = rst ? w_grant : '0;
  assign w_accept  = w_found & rst;
  assign w_ptr_nxt = (w_gidx == PTR_W'(N_REQ-1)) ? '0 : w_gidx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr      <= '0;
      r_rom_addr <= '0;
      r_tag_vld  <= '0;
      r_tag_idx  <= '0;
    end else begin
      // The ROM is never stalled, so the tag pipeline shifts every clock.
      r_tag_vld <= {r_tag_vld[ROM_LAT-1:0], w_accept};
      r_tag_idx <= {r_tag_idx[ROM_LAT-1:0], w_gidx};
      if (w_accept) begin
        r_rom_addr <= req_addr[w_gidx*ADDR_W +: ADDR_W];
        r_ptr      <= w_ptr_nxt;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (r_tag_vld[ROM_LAT]) begin
      rsp_valid[r_tag_idx[ROM_LAT]] = 1'b1;
    end
  end

  assign rom_addr = r_rom_addr;
  assign rsp_data = rom_data;

endmodule

// File: tb/tb_font_rom_arbiter.sv
module tb_font_rom_arbiter;

  logic        clk;
  logic        rst1, rst2;
  logic [2:0]  req_valid1, req_valid2;
  logic [32:0] req_addr1, req_addr2;
  logic [2:0]  req_ready1, req_ready2;
  logic [10:0] rom_addr1, rom_addr2;
  logic [7:0]  rom_data1, rom_data2;
  logic [2:0]  rsp_valid1, rsp_valid2;
  logic [7:0]  rsp_data1, rsp_data2;
  logic [7:0]  rom2_d [3];

  int n_checks;
  int n_fail;

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         due;
  } exp_t;

  font_rom_arbiter #(.N_REQ(3), .ADDR_W(11), .DATA_W(8), .ROM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_addr(req_addr1),
    .req_ready(req_ready1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1)
  );

  font_rom_arbiter #(.N_REQ(3), .ADDR_W(11), .DATA_W(8), .ROM_LAT(3)) u_dut2 (
    .clk(clk), .rst(rst2), .req_valid(req_valid2), .req_addr(req_addr2),
    .req_ready(req_ready2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Font ROM models: data = addr[7:0] ^ 8'hA5
  always @(posedge clk) rom_data1 <= rom_addr1[7:0] ^ 8'hA5;
  always @(posedge clk) begin
    rom2_d[0] <= rom_addr2[7:0] ^ 8'hA5;
    rom2_d[1] <= rom2_d[0];
    rom2_d[2] <= rom2_d[1];
  end
  assign rom_data2 = rom2_d[2];

  task automatic test_reset();
    rst1 = 1'b0;
    req_valid1 = 3'b111;
    req_addr1 = {11'h030, 11'h020, 11'h010};
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if (req_ready1 !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready: got %b expected %b", req_ready1, 3'b000);
    end
    n_checks++;
    if (rsp_valid1 !== 3'b000) begin
      n_fail++; $display("FAIL reset_rsp_valid: got %b expected %b", rsp_valid1, 3'b000);
    end
    n_checks++;
    if (rom_addr1 !== 11'h000) begin
      n_fail++; $display("FAIL reset_rom_addr: got %h expected %h", rom_addr1, 11'h000);
    end
    rst1 = 1'b1;
    #1;
    n_checks++;
    if (req_ready1 !== 3'b001) begin
      n_fail++; $display("FAIL reset_first_grant: got %b expected %b", req_ready1, 3'b001);
    end
    @(posedge clk); #1;
    req_valid1 = 3'b000;
    n_checks++;
    if (rom_addr1 !== 11'h010) begin
      n_fail++; $display("FAIL reset_first_addr: got %h expected %h", rom_addr1, 11'h010);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid1 !== 3'b001 || rsp_data1 !== 8'hB5) begin
      n_fail++;
      $display("FAIL reset_first_rsp: got %b/%h expected %b/%h", rsp_valid1, rsp_data1, 3'b001, 8'hB5);
    end
  endtask

  task automatic test_single();
    req_valid1 = 3'b010;
    req_addr1 = {11'h000, 11'h412, 11'h000};
    #1;
    n_checks++;
    if (req_ready1 !== 3'b010) begin
      n_fail++; $display("FAIL single_ready: got %b expected %b", req_ready1, 3'b010);
    end
    @(posedge clk); #1;
    req_valid1 = 3'b000;
    n_checks++;
    if (rom_addr1 !== 11'h412) begin
      n_fail++; $display("FAIL single_rom_addr: got %h expected %h", rom_addr1, 11'h412);
    end
    n_checks++;
    if (rsp_valid1 !== 3'b000) begin
      n_fail++; $display("FAIL single_rsp_early: got %b expected %b", rsp_valid1, 3'b000);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid1 !== 3'b010 || rsp_data1 !== 8'hB7) begin
      n_fail++;
      $display("FAIL single_rsp: got %b/%h expected %b/%h", rsp_valid1, rsp_data1, 3'b010, 8'hB7);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid1 !== 3'b000) begin
      n_fail++; $display("FAIL single_rsp_once: got %b expected %b", rsp_valid1, 3'b000);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] dtab [3];
    logic [2:0] exp_rdy, exp_rsp;
    dtab[0] = 8'hB5; dtab[1] = 8'h85; dtab[2] = 8'h95;
    // Start from ptr=0
    rst1 = 1'b0;
    @(posedge clk); #1;
    rst1 = 1'b1;
    req_addr1 = {11'h030, 11'h020, 11'h010};
    for (int j = 0; j < 8; j++) begin
      req_valid1 = (j < 6) ? 3'b111 : 3'b000;
      #1;
      exp_rdy = (j < 6) ? 3'(1 << (j % 3)) : 3'b000;
      n_checks++;
      if (req_ready1 !== exp_rdy) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", j, req_ready1, exp_rdy);
      end
      @(posedge clk); #1;
      exp_rsp = (j >= 1 && j <= 6) ? 3'(1 << ((j - 1) % 3)) : 3'b000;
      n_checks++;
      if (rsp_valid1 !== exp_rsp) begin
        n_fail++; $display("FAIL rr_rsp_valid[%0d]: got %b expected %b", j, rsp_valid1, exp_rsp);
      end
      if (exp_rsp != 3'b000) begin
        n_checks++;
        if (rsp_data1 !== dtab[(j - 1) % 3]) begin
          n_fail++;
          $display("FAIL rr_rsp_data[%0d]: got %h expected %h", j, rsp_data1, dtab[(j - 1) % 3]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] etab [3];
    etab[0] = 3'b001; etab[1] = 3'b010; etab[2] = 3'b001;
    // Grant req1 alone so the pointer lands on 2
    req_valid1 = 3'b010;
    #1;
    n_checks++;
    if (req_ready1 !== 3'b010) begin
      n_fail++; $display("FAIL wrap_setup: got %b expected %b", req_ready1, 3'b010);
    end
    @(posedge clk); #1;
    req_valid1 = 3'b011;
    for (int j = 0; j < 3; j++) begin
      #1;
      n_checks++;
      if (req_ready1 !== etab[j]) begin
        n_fail++; $display("FAIL wrap_grant[%0d]: got %b expected %b", j, req_ready1, etab[j]);
      end
      @(posedge clk); #1;
    end
    req_valid1 = 3'b000;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_back_to_back();
    logic [10:0] atab [4];
    logic [7:0]  dtab [4];
    atab[0] = 11'h155; atab[1] = 11'h1AA; atab[2] = 11'h7FF; atab[3] = 11'h000;
    dtab[0] = 8'hF0;   dtab[1] = 8'h0F;   dtab[2] = 8'h5A;   dtab[3] = 8'hA5;
    for (int j = 0; j < 5; j++) begin
      req_valid1 = (j < 4) ? 3'b001 : 3'b000;
      if (j < 4) req_addr1[10:0] = atab[j];
      #1;
      n_checks++;
      if (req_ready1 !== ((j < 4) ? 3'b001 : 3'b000)) begin
        n_fail++; $display("FAIL b2b_grant[%0d]: got %b", j, req_ready1);
      end
      @(posedge clk); #1;
      if (j < 4) begin
        n_checks++;
        if (rom_addr1 !== atab[j]) begin
          n_fail++; $display("FAIL b2b_rom_addr[%0d]: got %h expected %h", j, rom_addr1, atab[j]);
        end
      end
      if (j >= 1) begin
        n_checks++;
        if (rsp_valid1 !== 3'b001 || rsp_data1 !== dtab[j - 1]) begin
          n_fail++;
          $display("FAIL b2b_rsp[%0d]: got %b/%h expected %b/%h", j, rsp_valid1, rsp_data1, 3'b001, dtab[j - 1]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    req_valid1 = 3'b100;
    req_addr1 = {11'h0C3, 11'h000, 11'h000};
    #1;
    n_checks++;
    if (req_ready1 !== 3'b100) begin
      n_fail++; $display("FAIL mid_grant: got %b expected %b", req_ready1, 3'b100);
    end
    @(posedge clk); #1;
    rst1 = 1'b0;
    req_valid1 = 3'b000;
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid1 !== 3'b000) begin
      n_fail++; $display("FAIL mid_rsp_in_reset: got %b expected %b", rsp_valid1, 3'b000);
    end
    n_checks++;
    if (rom_addr1 !== 11'h000) begin
      n_fail++; $display("FAIL mid_rom_addr: got %h expected %h", rom_addr1, 11'h000);
    end
    rst1 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid1 !== 3'b000) begin
        n_fail++; $display("FAIL mid_rsp_after[%0d]: got %b expected %b", j, rsp_valid1, 3'b000);
      end
    end
    req_valid1 = 3'b111;
    #1;
    n_checks++;
    if (req_ready1 !== 3'b001) begin
      n_fail++; $display("FAIL mid_ptr_zero: got %b expected %b", req_ready1, 3'b001);
    end
    req_valid1 = 3'b000;
    #1;
  endtask

  task automatic test_lat3_single();
    logic [2:0] exp_rsp;
    @(posedge clk); #1;
    rst2 = 1'b1;
    req_valid2 = 3'b010;
    req_addr2 = {11'h000, 11'h412, 11'h000};
    #1;
    n_checks++;
    if (req_ready2 !== 3'b010) begin
      n_fail++; $display("FAIL lat3_grant: got %b expected %b", req_ready2, 3'b010);
    end
    @(posedge clk); #1;
    req_valid2 = 3'b000;
    for (int m = 1; m <= 5; m++) begin
      @(posedge clk); #1;
      exp_rsp = (m == 3) ? 3'b010 : 3'b000;
      n_checks++;
      if (rsp_valid2 !== exp_rsp) begin
        n_fail++; $display("FAIL lat3_rsp_valid[+%0d]: got %b expected %b", m, rsp_valid2, exp_rsp);
      end
      if (m == 3) begin
        n_checks++;
        if (rsp_data2 !== 8'hB7) begin
          n_fail++; $display("FAIL lat3_rsp_data: got %h expected %h", rsp_data2, 8'hB7);
        end
      end
    end
  endtask

  task automatic test_lat3_random();
    exp_t       q[$];
    exp_t       e;
    int         mptr;
    int         cyc;
    int         g;
    logic [2:0] exp_rdy;
    logic [2:0] exp_rsp;
    rst2 = 1'b0;
    @(posedge clk); #1;
    rst2 = 1'b1;
    mptr = 0;
    cyc = 0;
    for (int n = 0; n < 404; n++) begin
      req_valid2 = (n < 400) ? 3'($urandom_range(0, 7)) : 3'b000;
      for (int i = 0; i < 3; i++) req_addr2[i*11 +: 11] = 11'($urandom);
      #1;
      g = -1;
      for (int k = 0; k < 3; k++) begin
        if (g < 0 && req_valid2[(mptr + k) % 3]) g = (mptr + k) % 3;
      end
      exp_rdy = (g < 0) ? 3'b000 : 3'(1 << g);
      n_checks++;
      if (req_ready2 !== exp_rdy) begin
        n_fail++; $display("FAIL rnd_grant[%0d]: got %b expected %b", n, req_ready2, exp_rdy);
      end
      if (g >= 0) begin
        e.idx = g;
        e.data = req_addr2[g*11 +: 8] ^ 8'hA5;
        e.due = cyc + 1 + 3;
        q.push_back(e);
        mptr = (g + 1) % 3;
      end
      @(posedge clk); cyc++; #1;
      exp_rsp = 3'b000;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        exp_rsp = 3'(1 << e.idx);
        n_checks++;
        if (rsp_data2 !== e.data) begin
          n_fail++; $display("FAIL rnd_rsp_data[%0d]: got %h expected %h", n, rsp_data2, e.data);
        end
      end
      n_checks++;
      if (rsp_valid2 !== exp_rsp) begin
        n_fail++; $display("FAIL rnd_rsp_valid[%0d]: got %b expected %b", n, rsp_valid2, exp_rsp);
      end
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL rnd_drain: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst1 = 1'b0;
    rst2 = 1'b0;
    req_valid1 = 3'b000;
    req_valid2 = 3'b000;
    req_addr1 = '0;
    req_addr2 = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_back_to_back();
    test_reset_midflight();
    test_lat3_single();
    test_lat3_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
